// File: rtl/microwave_timer_ctrl.sv
// Microwave oven controller: one-hot door/cook/pause/bell/open FSM with countdown,
// duty-cycled power and timed bell. Define MWO_CHILD_LOCK_EN to add the lock input.
module microwave_timer_ctrl #(
    parameter int TIME_W     = 8,
    parameter int TICK_DIV   = 1000,
    parameter int PWR_W      = 2,
    parameter int BELL_UNITS = 3
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              door,
    input  logic              start,
    input  logic              cancel,
`ifdef MWO_CHILD_LOCK_EN
    input  logic              lock,
`endif
    input  logic [TIME_W-1:0] time_load,
    input  logic [PWR_W-1:0]  power,
    output logic              heat,
    output logic              light,
    output logic              bell,
    output logic              busy,
    output logic              done,
    output logic [TIME_W-1:0] remaining
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = $clog2(BELL_UNITS + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BELL_LD = BW'(BELL_UNITS - 1);

    localparam int I_CLOSED = 0;
    localparam int I_COOK   = 1;
    localparam int I_PAUSE  = 2;
    localparam int I_BELL   = 3;
    localparam int I_OPEN   = 4;

    typedef enum logic [4:0] {
        S_CLOSED = 5'b00001,
        S_COOK   = 5'b00010,
        S_PAUSE  = 5'b00100,
        S_BELL   = 5'b01000,
        S_OPEN   = 5'b10000
    } state_t;

    state_t            state, state_n;
    logic [TIME_W-1:0] rem_q, rem_n;
    logic [PW-1:0]     pre_q, pre_n;
    logic [PWR_W-1:0]  phase_q, phase_n;
    logic [PWR_W-1:0]  pwr_q, pwr_n;
    logic [BW-1:0]     bcnt_q, bcnt_n;
    logic              done_q, done_n;
    logic              tick;
    logic              lock_on;
    logic              to_idle;

`ifdef MWO_CHILD_LOCK_EN
    assign lock_on = lock;
`else
    assign lock_on = 1'b0;
`endif

    assign tick = (state[I_COOK] | state[I_BELL]) & (pre_q == PRE_MAX);
    assign to_idle = cancel;

    always_comb begin
        state_n = state;
        rem_n   = rem_q;
        pre_n   = pre_q;
        phase_n = phase_q;
        pwr_n   = pwr_q;
        bcnt_n  = bcnt_q;
        unique case (1'b1)
            state[I_CLOSED]: begin
                if (door) begin
                    state_n = S_OPEN;
                end else if (start && !lock_on && time_load != '0) begin
                    state_n = S_COOK;
                    rem_n   = time_load;
                    pwr_n   = power;
                    pre_n   = '0;
                    phase_n = '0;
                end
            end
            state[I_COOK]: begin
                if (to_idle) begin
                    state_n = door ? S_OPEN : S_CLOSED;
                    rem_n   = '0;
                end else if (door) begin
                    // door opening freezes the timing state mid-unit
                    state_n = S_PAUSE;
                end else begin
                    pre_n = tick ? '0 : pre_q + PW'(1);
                    if (tick) begin
                        phase_n = phase_q + PWR_W'(1);
                        if (rem_q <= TIME_W'(1)) begin
                            state_n = S_BELL;
                            rem_n   = '0;
                            pre_n   = '0;
                            bcnt_n  = BELL_LD;
                        end else begin
                            rem_n = rem_q - TIME_W'(1);
                        end
                    end
                end
            end
            state[I_PAUSE]: begin
                if (to_idle) begin
                    state_n = door ? S_OPEN : S_CLOSED;
                    rem_n   = '0;
                end else if (!door && !lock_on) begin
                    state_n = S_COOK;
                end
            end
            state[I_BELL]: begin
                if (door) begin
                    state_n = S_OPEN;
                end else begin
                    pre_n = tick ? '0 : pre_q + PW'(1);
                    if (tick) begin
                        if (bcnt_q == '0) begin
                            state_n = S_CLOSED;
                        end else begin
                            bcnt_n = bcnt_q - BW'(1);
                        end
                    end
                end
            end
            state[I_OPEN]: begin
                if (!door) begin
                    state_n = S_CLOSED;
                end
            end
            default: begin
                state_n = S_CLOSED;
                rem_n   = '0;
            end
        endcase
        done_n = (state_n == S_BELL) && (state != S_BELL);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= S_CLOSED;
            rem_q   <= '0;
            pre_q   <= '0;
            phase_q <= '0;
            pwr_q   <= '0;
            bcnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            rem_q   <= rem_n;
            pre_q   <= pre_n;
            phase_q <= phase_n;
            pwr_q   <= pwr_n;
            bcnt_q  <= bcnt_n;
            done_q  <= done_n;
        end
    end

    assign heat      = state[I_COOK] & (phase_q <= pwr_q);
    assign light     = state[I_COOK] | state[I_PAUSE] | state[I_OPEN];
    assign bell      = state[I_BELL];
    assign busy      = state[I_COOK] | state[I_PAUSE];
    assign done      = done_q;
    assign remaining = rem_q;

endmodule
